// File: rtl/game_pkg.sv
// Types shared by game_state_sel and the penalty shootout scheduler: game
// state/mode encodings, scheduler FSM states and default rule constants.
package game_pkg;

  typedef enum logic [1:0] {
    START   = 2'd0,
    KEEPER  = 2'd1,
    SHOOTER = 2'd2,
    FINISH  = 2'd3
  } g_state;

  typedef enum logic {
    SOLO  = 1'b0,
    MULTI = 1'b1
  } g_mode;

  typedef enum logic [2:0] {
    SCH_IDLE      = 3'd0,
    SCH_WAIT_SHOT = 3'd1,
    SCH_EVAL      = 3'd2,
    SCH_PAUSE     = 3'd3,
    SCH_DONE      = 3'd4
  } sched_state;

  localparam int DEFAULT_REG_SHOTS      = 5;
  localparam int DEFAULT_MAX_SHOTS      = 15;
  localparam int DEFAULT_SOLO_WIN_SAVES = 3;
  localparam int DEFAULT_SWITCH_DELAY   = 65_000_000;

endpackage

// File: rtl/penalty_match_scheduler_if.sv
// Signals between the gameplay/game_state_sel side (master) and the
// penalty shootout scheduler (slave).
interface penalty_match_scheduler_if;
  import game_pkg::*;

  // Shot handshake: shot_done is a one-cycle valid pulse qualified by
  // shot_goal; there is no ready, the scheduler accepts it only in WAIT_SHOT
  // and silently drops it in every other state.
  g_state     game_state;
  g_mode      game_mode;
  logic       shot_done;
  logic       shot_goal;
  logic       end_gk;
  logic       end_sh;
  logic       match_end;
  logic       match_result;
  logic [3:0] score_player;
  logic [3:0] score_enemy;
  logic [3:0] shots_player;
  logic [3:0] shots_enemy;
  logic       sudden_death;

  modport master (
    output game_state, game_mode, shot_done, shot_goal,
    input  end_gk, end_sh, match_end, match_result,
    input  score_player, score_enemy, shots_player, shots_enemy, sudden_death
  );

  modport slave (
    input  game_state, game_mode, shot_done, shot_goal,
    output end_gk, end_sh, match_end, match_result,
    output score_player, score_enemy, shots_player, shots_enemy, sudden_death
  );

endinterface

// File: rtl/penalty_match_scheduler_match_rules.sv
// Combinational shootout decision: regulation, sudden death and shot cap in
// MULTI, save/goal thresholds on enemy shots in SOLO.
module match_rules
  import game_pkg::*;
#(
  parameter int REG_SHOTS      = DEFAULT_REG_SHOTS,
  parameter int MAX_SHOTS      = DEFAULT_MAX_SHOTS,
  parameter int SOLO_WIN_SAVES = DEFAULT_SOLO_WIN_SAVES
) (
  input  logic [3:0] p_i,
  input  logic [3:0] e_i,
  input  logic [3:0] np_i,
  input  logic [3:0] ne_i,
  input  g_mode      game_mode_i,
  output logic       decided_o,
  output logic       result_o
);

  localparam logic [4:0] REG5   = 5'(REG_SHOTS);
  localparam logic [4:0] MAX5   = 5'(MAX_SHOTS);
  localparam logic [4:0] SAVES5 = 5'(SOLO_WIN_SAVES);
  localparam logic [4:0] LOSE5  = 5'(REG_SHOTS - SOLO_WIN_SAVES);

  logic [4:0] p5, e5, np5, ne5;
  logic       in_reg, in_sd, reg_dec, sd_dec, cap_dec, solo_win, solo_lose;

  assign p5  = {1'b0, p_i};
  assign e5  = {1'b0, e_i};
  assign np5 = {1'b0, np_i};
  assign ne5 = {1'b0, ne_i};

  always_comb begin
    in_reg    = (np5 <= REG5) && (ne5 <= REG5);
    in_sd     = (np5 >= REG5) && (ne5 >= REG5);
    // Remaining-shot terms only matter inside regulation, where they cannot go negative.
    reg_dec   = in_reg && (((p5 + (REG5 - np5)) < e5) || ((e5 + (REG5 - ne5)) < p5));
    sd_dec    = in_sd && (np5 == ne5) && (p5 != e5);
    cap_dec   = (np5 == MAX5) && (ne5 == MAX5) && (p5 == e5);
    solo_win  = (ne5 - e5) >= SAVES5;
    solo_lose = e5 > LOSE5;

    decided_o = 1'b0;
    result_o  = 1'b0;
    if (game_mode_i == SOLO) begin
      decided_o = solo_win || solo_lose;
      result_o  = solo_win;
    end else begin
      decided_o = reg_dec || sd_dec || cap_dec;
      result_o  = p5 > e5;
    end
  end

endmodule

// File: rtl/penalty_match_scheduler.sv
// Penalty shootout sequencer: counts shots/goals, decides the match and
// paces role swaps with a display pause after every unresolved shot.
module penalty_match_scheduler
  import game_pkg::*;
#(
  parameter int REG_SHOTS      = DEFAULT_REG_SHOTS,
  parameter int MAX_SHOTS      = DEFAULT_MAX_SHOTS,
  parameter int SOLO_WIN_SAVES = DEFAULT_SOLO_WIN_SAVES,
  parameter int SWITCH_DELAY   = DEFAULT_SWITCH_DELAY
) (
  input  logic                            clk,
  input  logic                            rst,
  penalty_match_scheduler_if.slave        bus,
  output sched_state                      state_o
);

  localparam int CNT_W = (SWITCH_DELAY > 1) ? $clog2(SWITCH_DELAY) : 1;
  localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(SWITCH_DELAY - 1);

  sched_state       state_q, state_d;
  logic [CNT_W-1:0] pause_q, pause_d;
  logic [3:0]       score_p_q, score_p_d, score_e_q, score_e_d;
  logic [3:0]       shots_p_q, shots_p_d, shots_e_q, shots_e_d;
  logic             match_end_q, match_end_d, result_q, result_d;
  logic             end_gk_q, end_gk_d, end_sh_q, end_sh_d;
  logic             decided, result;

  match_rules #(
    .REG_SHOTS      (REG_SHOTS),
    .MAX_SHOTS      (MAX_SHOTS),
    .SOLO_WIN_SAVES (SOLO_WIN_SAVES)
  ) u_rules (
    .p_i         (score_p_q),
    .e_i         (score_e_q),
    .np_i        (shots_p_q),
    .ne_i        (shots_e_q),
    .game_mode_i (bus.game_mode),
    .decided_o   (decided),
    .result_o    (result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCH_IDLE;
      pause_q     <= '0;
      score_p_q   <= '0;
      score_e_q   <= '0;
      shots_p_q   <= '0;
      shots_e_q   <= '0;
      match_end_q <= 1'b0;
      result_q    <= 1'b0;
      end_gk_q    <= 1'b0;
      end_sh_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pause_q     <= pause_d;
      score_p_q   <= score_p_d;
      score_e_q   <= score_e_d;
      shots_p_q   <= shots_p_d;
      shots_e_q   <= shots_e_d;
      match_end_q <= match_end_d;
      result_q    <= result_d;
      end_gk_q    <= end_gk_d;
      end_sh_q    <= end_sh_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pause_d     = pause_q;
    score_p_d   = score_p_q;
    score_e_d   = score_e_q;
    shots_p_d   = shots_p_q;
    shots_e_d   = shots_e_q;
    match_end_d = match_end_q;
    result_d    = result_q;
    end_gk_d    = 1'b0;
    end_sh_d    = 1'b0;

    // START aborts from anywhere and outranks a shot arriving in the same cycle.
    if (bus.game_state == START) begin
      state_d     = SCH_IDLE;
      pause_d     = '0;
      score_p_d   = '0;
      score_e_d   = '0;
      shots_p_d   = '0;
      shots_e_d   = '0;
      match_end_d = 1'b0;
      result_d    = 1'b0;
    end else begin
      unique case (state_q)
        SCH_IDLE: begin
          if (bus.game_state == KEEPER || bus.game_state == SHOOTER) state_d = SCH_WAIT_SHOT;
        end
        SCH_WAIT_SHOT: begin
          if (bus.shot_done && bus.game_state == KEEPER) begin
            shots_e_d = shots_e_q + 4'd1;
            score_e_d = score_e_q + 4'(bus.shot_goal);
            state_d   = SCH_EVAL;
          end else if (bus.shot_done && bus.game_state == SHOOTER) begin
            shots_p_d = shots_p_q + 4'd1;
            score_p_d = score_p_q + 4'(bus.shot_goal);
            state_d   = SCH_EVAL;
          end
        end
        SCH_EVAL: begin
          if (decided) begin
            state_d     = SCH_DONE;
            match_end_d = 1'b1;
            result_d    = result;
          end else begin
            state_d = SCH_PAUSE;
            pause_d = '0;
          end
        end
        SCH_PAUSE: begin
          if (pause_q == PAUSE_LAST) begin
            state_d = SCH_WAIT_SHOT;
            if (bus.game_mode == MULTI) begin
              end_gk_d = (bus.game_state == KEEPER);
              end_sh_d = (bus.game_state == SHOOTER);
            end
          end else begin
            pause_d = pause_q + 1'b1;
          end
        end
        SCH_DONE: begin
          state_d = SCH_DONE;
        end
        default: state_d = SCH_IDLE;
      endcase
    end
  end

  assign bus.end_gk       = end_gk_q;
  assign bus.end_sh       = end_sh_q;
  assign bus.match_end    = match_end_q;
  assign bus.match_result = result_q;
  assign bus.score_player = score_p_q;
  assign bus.score_enemy  = score_e_q;
  assign bus.shots_player = shots_p_q;
  assign bus.shots_enemy  = shots_e_q;
  assign bus.sudden_death = (shots_p_q >= 4'(REG_SHOTS)) && (shots_e_q >= 4'(REG_SHOTS))
                            && !match_end_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_penalty_match_scheduler.sv
// Directed bench for the penalty shootout scheduler with a short display pause.
module tb_penalty_match_scheduler;
  import game_pkg::*;

  localparam int SWITCH_DELAY = 4;
  localparam int PULSE_CYCLE  = SWITCH_DELAY + 2;

  logic       clk;
  logic       rst;
  sched_state state_o;
  int         n_vec;
  int         n_err;
  logic [3:0] m_p, m_e, m_np, m_ne;
  logic [15:0] exp_q[$];

  penalty_match_scheduler_if bus();

  penalty_match_scheduler #(
    .REG_SHOTS      (5),
    .MAX_SHOTS      (15),
    .SOLO_WIN_SAVES (3),
    .SWITCH_DELAY   (SWITCH_DELAY)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .state_o (state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {11'b0, bus.end_gk, bus.end_sh, bus.match_end, bus.match_result, bus.sudden_death,
            bus.score_player, bus.score_enemy, bus.shots_player, bus.shots_enemy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Abort to START, clear the model, then enter the first role.
  task automatic start_match(input g_mode md, input g_state gs);
    bus.game_state = START;
    bus.shot_done  = 1'b0;
    tick();
    tick();
    check_eq("abort_state", 32'(state_o), 32'(SCH_IDLE));
    check_eq("abort_outs", outs(), 32'h0);
    m_p = 0; m_e = 0; m_np = 0; m_ne = 0;
    bus.game_mode  = md;
    bus.game_state = gs;
    tick();
    check_eq("enter_wait", 32'(state_o), 32'(SCH_WAIT_SHOT));
  endtask

  // One shot: score check one cycle later, decision two cycles later,
  // otherwise the swap pulse timing and resumption of WAIT_SHOT.
  task automatic shot(input g_state gs, input logic goal, input logic exp_end, input logic exp_res);
    int   pulse_c;
    logic saw_gk, saw_sh;
    bus.game_state = gs;
    bus.shot_done  = 1'b1;
    bus.shot_goal  = goal;
    if (gs == KEEPER) begin
      m_ne = m_ne + 4'd1;
      m_e  = m_e + 4'(goal);
    end else begin
      m_np = m_np + 4'd1;
      m_p  = m_p + 4'(goal);
    end
    exp_q.push_back({m_p, m_e, m_np, m_ne});
    tick();
    bus.shot_done = 1'b0;
    bus.shot_goal = 1'b0;
    check_eq("scores", {16'b0, bus.score_player, bus.score_enemy, bus.shots_player, bus.shots_enemy},
             {16'b0, exp_q.pop_front()});
    tick();
    check_eq("match_end", 32'(bus.match_end), 32'(exp_end));
    if (exp_end) begin
      check_eq("match_result", 32'(bus.match_result), 32'(exp_res));
    end else begin
      pulse_c = 0;
      saw_gk  = 1'b0;
      saw_sh  = 1'b0;
      for (int c = 3; c <= 12; c++) begin
        tick();
        if (bus.end_gk) begin saw_gk = 1'b1; pulse_c = c; end
        if (bus.end_sh) begin saw_sh = 1'b1; pulse_c = c; end
        if (state_o == SCH_WAIT_SHOT) break;
      end
      check_eq("resume_wait", 32'(state_o), 32'(SCH_WAIT_SHOT));
      if (bus.game_mode == MULTI) begin
        check_eq("pulse_cycle", 32'(pulse_c), 32'(PULSE_CYCLE));
        check_eq("pulse_kind", {30'b0, saw_gk, saw_sh}, (gs == KEEPER) ? 32'h2 : 32'h1);
      end else begin
        check_eq("solo_no_pulse", {30'b0, saw_gk, saw_sh}, 32'h0);
      end
    end
  endtask

  initial begin
    logic saw;
    n_vec = 0;
    n_err = 0;
    m_p = 0; m_e = 0; m_np = 0; m_ne = 0;
    rst            = 1'b1;
    bus.game_state = START;
    bus.game_mode  = MULTI;
    bus.shot_done  = 1'b0;
    bus.shot_goal  = 1'b0;
    tick();
    tick();
    check_eq("reset_outs", outs(), 32'h0);
    check_eq("reset_state", 32'(state_o), 32'(SCH_IDLE));

    // First keeper turn in MULTI, goal conceded.
    rst            = 1'b0;
    bus.game_state = KEEPER;
    tick();
    check_eq("keeper_state", 32'(state_o), 32'(SCH_WAIT_SHOT));
    check_eq("keeper_outs", outs(), 32'h0);
    shot(KEEPER, 1'b1, 1'b0, 1'b0);
    check_eq("first_shot", {16'b0, bus.score_enemy, bus.shots_enemy, 8'b0}, 32'h1100);

    // START mid-pause with a shot_done in the same cycle.
    bus.shot_done = 1'b1;
    bus.shot_goal = 1'b0;
    tick();
    bus.shot_done = 1'b0;
    tick();
    tick();
    check_eq("mid_pause", 32'(state_o), 32'(SCH_PAUSE));
    bus.game_state = START;
    bus.shot_done  = 1'b1;
    bus.shot_goal  = 1'b1;
    tick();
    bus.shot_done = 1'b0;
    bus.shot_goal = 1'b0;
    check_eq("abort_idle", 32'(state_o), 32'(SCH_IDLE));
    check_eq("abort_clear", outs(), 32'h0);
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      saw = saw | bus.end_gk | bus.end_sh;
    end
    check_eq("abort_no_pulse", 32'(saw), 32'h0);

    // MULTI: player 3/3, enemy misses 3/3, decided at np=ne=3.
    start_match(MULTI, SHOOTER);
    for (int i = 1; i <= 3; i++) begin
      shot(SHOOTER, 1'b1, 1'b0, 1'b0);
      shot(KEEPER, 1'b0, (i == 3), 1'b1);
    end
    // DONE holds and ignores further shots.
    bus.shot_done = 1'b1;
    bus.shot_goal = 1'b1;
    tick();
    bus.shot_done = 1'b0;
    tick();
    tick();
    check_eq("done_hold", {16'b0, bus.score_player, bus.score_enemy, bus.shots_player, bus.shots_enemy},
             32'h3033);
    check_eq("done_end", {30'b0, bus.match_end, bus.match_result}, 32'h3);

    // MULTI: 5-5 then sudden death, player wins 6-5.
    start_match(MULTI, KEEPER);
    for (int i = 1; i <= 5; i++) begin
      shot(KEEPER, 1'b1, 1'b0, 1'b0);
      if (i == 5) check_eq("sd_before", 32'(bus.sudden_death), 32'h0);
      shot(SHOOTER, 1'b1, 1'b0, 1'b0);
    end
    check_eq("sd_level", 32'(bus.sudden_death), 32'h1);
    shot(KEEPER, 1'b0, 1'b0, 1'b0);
    shot(SHOOTER, 1'b1, 1'b1, 1'b1);
    check_eq("sd_score", {24'b0, bus.score_player, bus.score_enemy}, 32'h65);
    check_eq("sd_cleared", 32'(bus.sudden_death), 32'h0);

    // MULTI: tie held to the shot cap.
    start_match(MULTI, KEEPER);
    for (int i = 1; i <= 15; i++) begin
      shot(KEEPER, 1'b1, 1'b0, 1'b0);
      shot(SHOOTER, 1'b1, (i == 15), 1'b0);
    end
    check_eq("cap_shots", {24'b0, bus.shots_player, bus.shots_enemy}, 32'hFF);
    check_eq("cap_sd_off", 32'(bus.sudden_death), 32'h0);

    // SOLO win: goal, save, save, save.
    start_match(SOLO, KEEPER);
    shot(KEEPER, 1'b1, 1'b0, 1'b0);
    shot(KEEPER, 1'b0, 1'b0, 1'b0);
    shot(KEEPER, 1'b0, 1'b0, 1'b0);
    shot(KEEPER, 1'b0, 1'b1, 1'b1);

    // SOLO loss: three goals conceded.
    start_match(SOLO, KEEPER);
    shot(KEEPER, 1'b1, 1'b0, 1'b0);
    shot(KEEPER, 1'b1, 1'b0, 1'b0);
    shot(KEEPER, 1'b1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
